// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: forwarding selects,
// FSM states and the shadow-entry field widths.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int REG_AW_DEF = 5;
  localparam int FLAG_W     = 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  function automatic logic [1:0] fwd_nz_count(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, (a != FWD_REG)} + {1'b0, (b != FWD_REG)};
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one ALU operand; the newer (EX) producer beats MEM,
// and a load in EX never forwards because its data is not ready yet.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  logic              ex_regwr,
  input  logic              ex_memtoreg,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic              mem_regwr,
  input  logic [REG_AW-1:0] mem_rw,
  output logic [1:0]        sel
);

  localparam logic [REG_AW-1:0] ZERO = {REG_AW{1'b0}};

  // Register $0 is hardwired, so a zero source never matches a producer.
  always_comb begin
    sel = FWD_REG;
    if (!use_src || (src == ZERO)) begin
      sel = FWD_REG;
    end else if (ex_regwr && !ex_memtoreg && (ex_rw == src)) begin
      sel = FWD_MEM;
    end else if (mem_regwr && (mem_rw == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// EX-stage forwarding selects plus load-use stall / branch flush control.
// Optional counters are enabled by defining HAZARD_STATS_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_regwr,
  input  logic              id_memtoreg,
  input  logic              ex_br_taken,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
  , output logic [CNT_W-1:0] fwd_cnt
`endif
);

  localparam logic [REG_AW-1:0] ZERO = {REG_AW{1'b0}};

  state_t              state, state_nxt;
  logic [FLAG_W-1:0]   ex_regwr, ex_memtoreg, mem_regwr;
  logic [REG_AW-1:0]   ex_rw, mem_rw;
  logic                luse, luse_eff, load_ex;
  logic [1:0]          sel_a, sel_b;

  assign luse = id_valid && ex_memtoreg[0] && ex_regwr[0] && (ex_rw != ZERO)
              && ((id_use_rs && (id_rs == ex_rw)) || (id_use_rt && (id_rt == ex_rw)));
  assign luse_eff = luse && (state != S_STALL);
  assign load_ex  = id_valid && !idex_bubble;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .use_src(id_use_rs), .src(id_rs),
    .ex_regwr(ex_regwr[0]), .ex_memtoreg(ex_memtoreg[0]), .ex_rw(ex_rw),
    .mem_regwr(mem_regwr[0]), .mem_rw(mem_rw), .sel(sel_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .use_src(id_use_rt), .src(id_rt),
    .ex_regwr(ex_regwr[0]), .ex_memtoreg(ex_memtoreg[0]), .ex_rw(ex_rw),
    .mem_regwr(mem_regwr[0]), .mem_rw(mem_rw), .sel(sel_b)
  );

  // State register, shadow pipeline and registered forwarding selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      ex_regwr    <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_rw       <= ZERO;
      mem_regwr   <= 1'b0;
      mem_rw      <= ZERO;
      fwd_a       <= FWD_REG;
      fwd_b       <= FWD_REG;
    end else begin
      state     <= state_nxt;
      mem_regwr <= ex_regwr;
      mem_rw    <= ex_rw;
      if (load_ex) begin
        ex_regwr    <= id_regwr;
        ex_memtoreg <= id_memtoreg;
        ex_rw       <= id_rw;
        fwd_a       <= sel_a;
        fwd_b       <= sel_b;
      end else begin
        ex_regwr    <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_rw       <= ZERO;
        fwd_a       <= FWD_REG;
        fwd_b       <= FWD_REG;
      end
    end
  end

  // Next state: a taken branch overrides any pending load-use stall.
  always_comb begin
    state_nxt = S_RUN;
    case (state)
      S_RUN, S_STALL, S_FLUSH: begin
        if (ex_br_taken) begin
          state_nxt = S_FLUSH;
        end else if (luse_eff) begin
          state_nxt = S_STALL;
        end else begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Pipeline control outputs for the current cycle.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      idex_bubble = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (luse_eff) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      idex_bubble = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] fwd_inc;

  assign fwd_inc = load_ex ? CNT_W'(fwd_nz_count(sel_a, sel_b)) : {CNT_W{1'b0}};

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (pc_hold && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
      if ((CNT_MAX - fwd_cnt) < fwd_inc) fwd_cnt <= CNT_MAX;
      else fwd_cnt <= fwd_cnt + fwd_inc;
    end
  end
`endif

endmodule
